fifo_ctrl_param: RTL and testbench
==================================

Name: fifo_ctrl_param

Overview:
- Parametrised synchronous FIFO: storage, pointers, occupancy count and a registered 6-state controller in one block.
- Successor to the fixed 32-entry FIFO next-state logic. Adds configurable width and depth, a same-cycle read+write mode, and registered handshake/error pulses.
- Sits between the factorial engine and the output interface as the result buffer.

Parameters:
- DATA_WIDTH, 32, width of din/dout.
- ADDR_WIDTH, 5, pointer width; DEPTH = 2**ADDR_WIDTH entries.
- AF_LEVEL, DEPTH-2, almost-full threshold (used only with the optional feature).
- AE_LEVEL, 2, almost-empty threshold (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- wr_en  in  1  write request.
- rd_en  in  1  read request.
- din  in  DATA_WIDTH  write data.
- dout  out  DATA_WIDTH  read data, registered.
- data_count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- full  out  1  data_count==DEPTH (combinational from count).
- empty  out  1  data_count==0 (combinational from count).
- wr_ack  out  1  one-cycle pulse: write accepted.
- wr_err  out  1  one-cycle pulse: write rejected.
- rd_ack  out  1  one-cycle pulse: read accepted, dout valid.
- rd_err  out  1  one-cycle pulse: read rejected.
- state  out  3  current controller state.

Behaviour:
- Reset (reset_n=0, asynchronous): state=IDLE; wr_ptr=rd_ptr=0; data_count=0; dout=0; all ack/err=0; empty=1, full=0. Memory contents are not reset.
- State encoding: IDLE=000, WRITE=001, READ=010, WR_ERROR=011, RD_ERROR=100, RDWR=101. Codes 110 and 111 recover to IDLE on the next edge.
- Every edge evaluates wr_en, rd_en and data_count, sampled before the edge. The same conditions set next state, datapath action and pulses, identically from every state. The state register records the last operation.
- wr_en=0, rd_en=0: no action; next=IDLE; all pulses 0.
- wr_en=1, rd_en=0:
  - count<DEPTH: mem[wr_ptr]<=din; wr_ptr+1; count+1; wr_ack=1; next=WRITE.
  - otherwise: no change; wr_err=1; next=WR_ERROR.
- wr_en=0, rd_en=1:
  - count>0: dout<=mem[rd_ptr]; rd_ptr+1; count-1; rd_ack=1; next=READ.
  - otherwise: dout holds; rd_err=1; next=RD_ERROR.
- wr_en=1, rd_en=1:
  - count>0 (including full): read and write both performed; count unchanged; wr_ack=rd_ack=1; next=RDWR. The read returns the old head entry, never the entry being written.
  - count==0: write only; count=1; wr_ack=1 and rd_err=1; next=WRITE.
- Latency:
  - Read data appears on dout in the same cycle that rd_ack is high, i.e. one edge after the request is sampled.
  - A written entry is readable on the edge after its wr_ack.
- Pointers wrap modulo DEPTH with no extra logic. data_count never exceeds DEPTH and never goes below 0.
- dout holds its last value whenever no read is accepted.
- Error states are not sticky: the next legal request leaves them in one edge.
- Reset asserted mid-operation aborts the operation immediately; all outputs return to reset values.

Optional Feature:
- Macro: FIFO_ALMOST_FLAGS_EN.
- Defined: extra outputs almost_full (data_count>=AF_LEVEL) and almost_empty (data_count<=AE_LEVEL), both combinational from data_count; after reset almost_full=0, almost_empty=1.
- Undefined: neither port exists; AF_LEVEL and AE_LEVEL are ignored; all other behaviour is identical.

Test Plan:
- Reset, then 1 cycle with rd_en=1 -> rd_err=1, state=100, data_count=0, dout=0, empty=1.
- Write 0x11..0x30 (32 words, ADDR_WIDTH=5) -> wr_ack every cycle, data_count=32, full=1. A 33rd write -> wr_err=1, state=011, count stays 32.
- From full, hold wr_en=rd_en=1 for 4 cycles writing 0xA0..0xA3 -> state=101, count stays 32, dout=0x11,0x12,0x13,0x14. Then drain 32 reads -> last four outputs 0xA0..0xA3.
- Empty FIFO, wr_en=rd_en=1, din=0x55 -> wr_ack=1, rd_err=1, state=001, count=1. Next cycle read -> dout=0x55, rd_ack=1, empty=1.
- Write 3 words, read 2, idle 1 cycle -> state 001,001,001,010,010,000; count 1,2,3,2,1,1. Then assert reset_n=0 mid-write -> count=0, state=000 asynchronously.
- With FIFO_ALMOST_FLAGS_EN, AF_LEVEL=30, AE_LEVEL=2: fill to 30 -> almost_full=1 at count 30, 0 at 29. Drain to 2 -> almost_empty=1 at count 2.

Source files
------------

// File: rtl/fifo_ctrl_param.sv
// Parametrised synchronous FIFO used as the factorial result buffer.
// Storage, pointers, occupancy count and a registered 6-state controller.
//
// Ports:
//   clk, reset_n      clock (rising edge), asynchronous active-low reset
//   wr_en, din        write request and data
//   rd_en, dout       read request and registered read data
//   data_count        occupancy 0..DEPTH; full/empty decoded from it
//   wr_ack, wr_err    registered one-cycle write accept/reject pulses
//   rd_ack, rd_err    registered one-cycle read accept/reject pulses
//   state             last operation: IDLE, WRITE, READ, WR_ERROR,
//                     RD_ERROR, RDWR
//   almost_full/_empty  only when FIFO_ALMOST_FLAGS_EN is defined
module fifo_ctrl_param #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int AF_LEVEL   = (2 ** ADDR_WIDTH) - 2,
    parameter int AE_LEVEL   = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic [ADDR_WIDTH:0]   data_count,
    output logic                  full,
    output logic                  empty,
    output logic                  wr_ack,
    output logic                  wr_err,
    output logic                  rd_ack,
    output logic                  rd_err,
    output logic [2:0]            state
`ifdef FIFO_ALMOST_FLAGS_EN
    ,
    output logic                  almost_full,
    output logic                  almost_empty
`endif
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic [2:0] {
        IDLE     = 3'b000,
        WRITE    = 3'b001,
        READ     = 3'b010,
        WR_ERROR = 3'b011,
        RD_ERROR = 3'b100,
        RDWR     = 3'b101
    } state_t;

    state_t                cur_state;
    state_t                nxt_state;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  do_wr;
    logic                  do_rd;
    logic                  wr_ack_n;
    logic                  wr_err_n;
    logic                  rd_ack_n;
    logic                  rd_err_n;

    assign full  = (data_count == FULL_CNT);
    assign empty = (data_count == '0);
    assign state = cur_state;

`ifdef FIFO_ALMOST_FLAGS_EN
    assign almost_full  = (data_count >= AF_LEVEL[ADDR_WIDTH:0]);
    assign almost_empty = (data_count <= AE_LEVEL[ADDR_WIDTH:0]);
`else
    logic unused_levels;
    assign unused_levels = ^{AF_LEVEL, AE_LEVEL};
`endif

    // Decisions depend only on the request pair and the count, never on
    // the current state, so the illegal codes 110/111 fall back to IDLE.
    always_comb begin
        nxt_state = IDLE;
        do_wr     = 1'b0;
        do_rd     = 1'b0;
        wr_ack_n  = 1'b0;
        wr_err_n  = 1'b0;
        rd_ack_n  = 1'b0;
        rd_err_n  = 1'b0;
        unique case ({wr_en, rd_en})
            2'b10: begin
                if (!full) begin
                    do_wr     = 1'b1;
                    wr_ack_n  = 1'b1;
                    nxt_state = WRITE;
                end else begin
                    wr_err_n  = 1'b1;
                    nxt_state = WR_ERROR;
                end
            end
            2'b01: begin
                if (!empty) begin
                    do_rd     = 1'b1;
                    rd_ack_n  = 1'b1;
                    nxt_state = READ;
                end else begin
                    rd_err_n  = 1'b1;
                    nxt_state = RD_ERROR;
                end
            end
            2'b11: begin
                // When full the read frees the slot being written; the
                // read samples mem before this edge's write lands.
                do_wr    = 1'b1;
                wr_ack_n = 1'b1;
                if (!empty) begin
                    do_rd     = 1'b1;
                    rd_ack_n  = 1'b1;
                    nxt_state = RDWR;
                end else begin
                    rd_err_n  = 1'b1;
                    nxt_state = WRITE;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur_state  <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            data_count <= '0;
            dout       <= '0;
            wr_ack     <= 1'b0;
            wr_err     <= 1'b0;
            rd_ack     <= 1'b0;
            rd_err     <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            wr_ack    <= wr_ack_n;
            wr_err    <= wr_err_n;
            rd_ack    <= rd_ack_n;
            rd_err    <= rd_err_n;
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                dout   <= mem[rd_ptr];
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_wr, do_rd})
                2'b10:   data_count <= data_count + 1'b1;
                2'b01:   data_count <= data_count - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: tb/tb_fifo_ctrl_param.sv
// Directed table-driven bench for fifo_ctrl_param (DEPTH=32).
// Define FIFO_ALMOST_FLAGS_EN to also check the almost flags.
module tb_fifo_ctrl_param;

    logic        clk;
    logic        reset_n;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] din;
    logic [31:0] dout;
    logic [5:0]  data_count;
    logic        full;
    logic        empty;
    logic        wr_ack;
    logic        wr_err;
    logic        rd_ack;
    logic        rd_err;
    logic [2:0]  state;
`ifdef FIFO_ALMOST_FLAGS_EN
    logic        almost_full;
    logic        almost_empty;
`endif

    int total;
    int bad;

    fifo_ctrl_param #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(5),
        .AF_LEVEL  (30),
        .AE_LEVEL  (2)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .wr_en       (wr_en),
        .rd_en       (rd_en),
        .din         (din),
        .dout        (dout),
        .data_count  (data_count),
        .full        (full),
        .empty       (empty),
        .wr_ack      (wr_ack),
        .wr_err      (wr_err),
        .rd_ack      (rd_ack),
        .rd_err      (rd_err),
        .state       (state)
`ifdef FIFO_ALMOST_FLAGS_EN
        ,
        .almost_full (almost_full),
        .almost_empty(almost_empty)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic        rd;
        logic [31:0] d;
        logic [2:0]  st;
        logic [5:0]  cnt;
        logic [3:0]  p;   // {wr_ack, wr_err, rd_ack, rd_err}
        logic [31:0] q;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic w, input logic r,
                                input logic [31:0] d, input logic [2:0] st,
                                input logic [5:0] c, input logic [3:0] p,
                                input logic [31:0] q);
        vec_t v;
        v.wr  = w;
        v.rd  = r;
        v.d   = d;
        v.st  = st;
        v.cnt = c;
        v.p   = p;
        v.q   = q;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h @%0t", nm, act, exp,
                     $time);
        end
    endtask

    task automatic chk_flags(input int idx, input logic [5:0] c);
        chk($sformatf("full[%0d]", idx), 32'(full), 32'(c == 6'd32));
        chk($sformatf("empty[%0d]", idx), 32'(empty), 32'(c == 6'd0));
`ifdef FIFO_ALMOST_FLAGS_EN
        chk($sformatf("afull[%0d]", idx), 32'(almost_full), 32'(c >= 6'd30));
        chk($sformatf("aempty[%0d]", idx), 32'(almost_empty), 32'(c <= 6'd2));
`endif
    endtask

    initial begin
        logic [31:0] fifo_q[$];
        logic [31:0] last;
        total   = 0;
        bad     = 0;
        reset_n = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        din     = '0;

        // Build the vector table with hand-derived expectations.
        last = 32'h0;
        add(0, 1, 32'h0, 3'b100, 6'd0, 4'b0001, last);
        for (int i = 0; i < 32; i++)
            add(1, 0, 32'h11 + i, 3'b001, 6'(i + 1), 4'b1000, last);
        add(1, 0, 32'h99, 3'b011, 6'd32, 4'b0100, last);
        for (int i = 0; i < 4; i++)
            add(1, 1, 32'hA0 + i, 3'b101, 6'd32, 4'b1010, 32'h11 + i);
        for (int i = 0; i < 28; i++)
            add(0, 1, 32'h0, 3'b010, 6'(31 - i), 4'b0010, 32'h15 + i);
        for (int i = 0; i < 4; i++)
            add(0, 1, 32'h0, 3'b010, 6'(3 - i), 4'b0010, 32'hA0 + i);
        last = 32'hA3;
        add(1, 1, 32'h55, 3'b001, 6'd1, 4'b1001, last);
        add(0, 1, 32'h0, 3'b010, 6'd0, 4'b0010, 32'h55);
        last = 32'h55;
        add(1, 0, 32'h61, 3'b001, 6'd1, 4'b1000, last);
        add(1, 0, 32'h62, 3'b001, 6'd2, 4'b1000, last);
        add(1, 0, 32'h63, 3'b001, 6'd3, 4'b1000, last);
        add(0, 1, 32'h0, 3'b010, 6'd2, 4'b0010, 32'h61);
        add(0, 1, 32'h0, 3'b010, 6'd1, 4'b0010, 32'h62);
        add(0, 0, 32'h0, 3'b000, 6'd1, 4'b0000, 32'h62);

        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst_count", 32'(data_count), 32'd0);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_dout", dout, 32'd0);
        chk("rst_pulses", 32'({wr_ack, wr_err, rd_ack, rd_err}), 32'd0);
        chk_flags(-1, 6'd0);
        reset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            wr_en = vecs[i].wr;
            rd_en = vecs[i].rd;
            din   = vecs[i].d;
            @(posedge clk);
            #1;
            chk($sformatf("state[%0d]", i), 32'(state), 32'(vecs[i].st));
            chk($sformatf("count[%0d]", i), 32'(data_count),
                32'(vecs[i].cnt));
            chk($sformatf("pulses[%0d]", i),
                32'({wr_ack, wr_err, rd_ack, rd_err}), 32'(vecs[i].p));
            chk($sformatf("dout[%0d]", i), dout, vecs[i].q);
            chk_flags(i, vecs[i].cnt);
        end

        // Reset asserted mid-write must clear everything asynchronously.
        @(negedge clk);
        wr_en = 1'b1;
        rd_en = 1'b0;
        din   = 32'h77;
        @(posedge clk);
        #1;
        chk("mw_count", 32'(data_count), 32'd2);
        #2;
        reset_n = 1'b0;
        #1;
        chk("ar_count", 32'(data_count), 32'd0);
        chk("ar_state", 32'(state), 32'd0);
        chk("ar_dout", dout, 32'd0);
        chk("ar_pulses", 32'({wr_ack, wr_err, rd_ack, rd_err}), 32'd0);
        chk("ar_empty", 32'(empty), 32'd1);

        // Post-reset: pointers restart, write then read back.
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("pr_count", 32'(data_count), 32'd1);
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b1;
        @(posedge clk);
        #1;
        chk("pr_dout", dout, 32'h77);
        chk("pr_rdack", 32'(rd_ack), 32'd1);
        chk("pr_state", 32'(state), 32'd2);
        @(negedge clk);
        rd_en = 1'b0;
        @(posedge clk);
        #1;
        chk("pr_idle", 32'(state), 32'd0);
        chk("pr_hold", dout, 32'h77);

        fifo_q.delete();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
